// File: rtl/im_fetch_responder.sv
// -----------------------------------------------------------------------------
// im_fetch_responder
//
// Instruction-memory responder for the IF stage. Accepts a byte fetch address,
// performs one read of a synchronous single-port instruction SRAM, optionally
// waits WAIT_CYCLES extra cycles, and returns the instruction with a one-cycle
// im_valid pulse. im_stall holds the PC while a fetch is outstanding.
//
// Parameters
//   ADDR_W       SRAM word-address width (2^ADDR_W 32-bit words)
//   WAIT_CYCLES  extra cycles after the SRAM read cycle (0..15)
//   RESET_INSTR  reset / flush value of im_instr (NOP)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   if_req       fetch request from the IF stage
//   if_addr      byte fetch address (only bits [ADDR_W+1:2] address the SRAM)
//   if_flush     redirect; cancels delivery of an in-flight fetch
//   im_instr     fetched instruction, registered, holds outside delivery
//   im_valid     one-cycle pulse, im_instr valid
//   im_stall     hold PC while a fetch is pending (combinational)
//   im_misalign  (MISALIGN_CHECK_EN only) pulses with im_valid for a
//                misaligned fetch that returned RESET_INSTR
//   sram_cs      SRAM chip select, registered, high for one cycle per read
//   sram_oe      SRAM output enable, same flop as sram_cs
//   sram_addr    SRAM word address, latched at acceptance
//   sram_rdata   SRAM read data, valid the cycle after sram_cs and held
//
// Build option
//   MISALIGN_CHECK_EN  when defined, a fetch with if_addr[1:0] != 0 is answered
//                      immediately with RESET_INSTR and im_misalign, without
//                      touching the SRAM. When undefined, if_addr[1:0] is
//                      ignored and im_misalign does not exist.
// -----------------------------------------------------------------------------
module im_fetch_responder #(
    parameter int          ADDR_W      = 14,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic [31:0]       im_instr,
    output logic              im_valid,
    output logic              im_stall,
`ifdef MISALIGN_CHECK_EN
    output logic              im_misalign,
`endif
    output logic              sram_cs,
    output logic              sram_oe,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       discard;   // a flush arrived while the SRAM read was in flight
    logic       valid_q;   // high exactly in the delivery cycle
    logic       misalign_q;
    logic       accept;
    logic       take;
    logic       misaligned;

    // Byte-address bits that never reach the SRAM; high bits simply wrap.
    logic       unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0]};

`ifdef MISALIGN_CHECK_EN
    assign misaligned = |if_addr[1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign accept = if_req & ~if_flush;
    // New fetches are taken from IDLE, or back-to-back from the delivery cycle.
    assign take   = accept & ((state == ST_IDLE) | (state == ST_RESP));

    // NOTE: every register below is updated with non-blocking assignments in a
    // single clocked block, so all reads see the pre-edge values and the order
    // of statements cannot create hidden combinational paths between flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            discard    <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            sram_cs    <= 1'b0;
            sram_addr  <= '0;
            im_instr   <= RESET_INSTR;
        end else begin
            // Pulsed outputs default low every cycle.
            sram_cs    <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end

                ST_ACCESS: begin
                    wait_cnt <= WAIT_INIT;
                    if (if_flush) begin
                        discard <= 1'b1;
                    end
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (if_flush) begin
                            discard <= 1'b1;
                        end
                    end else if (discard | if_flush) begin
                        // The read could not be cancelled; drop its data here.
                        im_instr <= RESET_INSTR;
                        discard  <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        im_instr <= sram_rdata;
                        valid_q  <= 1'b1;
                        state    <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (if_flush) begin
                        im_instr <= RESET_INSTR;
                    end
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Acceptance overrides the state chosen above (IDLE or RESP only).
            if (take) begin
                sram_addr <= if_addr[ADDR_W+1:2];
                if (misaligned) begin
                    im_instr   <= RESET_INSTR;
                    valid_q    <= 1'b1;
                    misalign_q <= 1'b1;
                    state      <= ST_RESP;
                end else begin
                    sram_cs <= 1'b1;
                    state   <= ST_ACCESS;
                end
            end
        end
    end

    assign sram_oe = sram_cs;

    // A flush in the delivery cycle suppresses the pulse in that same cycle.
    assign im_valid = valid_q & ~if_flush;

`ifdef MISALIGN_CHECK_EN
    assign im_misalign = misalign_q & ~if_flush;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

    // Stall also covers the acceptance cycle so the PC holds on that edge;
    // it drops in the delivery cycle so the PC advances as data arrives.
    assign im_stall = ~rst & ((state == ST_ACCESS) | (state == ST_WAIT) |
                              ((state == ST_IDLE) & accept));

endmodule

// File: tb/tb_im_fetch_responder.sv
// -----------------------------------------------------------------------------
// tb_im_fetch_responder
//
// Two responders share one stimulus stream: u0 with no wait states and u1 with
// three. Each has its own SRAM model backed by a common memory image. A
// transaction-level model (countdown to delivery per outstanding fetch) gives
// the expected outputs of both instances every cycle; directed sequences add
// hand-computed expectations at fixed cycle offsets.
// -----------------------------------------------------------------------------
module tb_im_fetch_responder;

    localparam int          AW    = 8;
    localparam int          W0    = 0;
    localparam int          W1    = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_flush = 1'b0;

    logic [31:0]   im_instr   [2];
    logic [1:0]    im_valid;
    logic [1:0]    im_stall;
    logic [1:0]    im_mis;
    logic [1:0]    sram_cs;
    logic [1:0]    sram_oe;
    logic [AW-1:0] sram_addr  [2];
    logic [31:0]   sram_rdata [2];

    logic [31:0] mem [1<<AW];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    im_fetch_responder #(.ADDR_W(AW), .WAIT_CYCLES(W0), .RESET_INSTR(NOP)) u0 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .im_instr(im_instr[0]), .im_valid(im_valid[0]), .im_stall(im_stall[0]),
`ifdef MISALIGN_CHECK_EN
        .im_misalign(im_mis[0]),
`endif
        .sram_cs(sram_cs[0]), .sram_oe(sram_oe[0]), .sram_addr(sram_addr[0]),
        .sram_rdata(sram_rdata[0])
    );

    im_fetch_responder #(.ADDR_W(AW), .WAIT_CYCLES(W1), .RESET_INSTR(NOP)) u1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .im_instr(im_instr[1]), .im_valid(im_valid[1]), .im_stall(im_stall[1]),
`ifdef MISALIGN_CHECK_EN
        .im_misalign(im_mis[1]),
`endif
        .sram_cs(sram_cs[1]), .sram_oe(sram_oe[1]), .sram_addr(sram_addr[1]),
        .sram_rdata(sram_rdata[1])
    );

`ifndef MISALIGN_CHECK_EN
    assign im_mis = 2'b00;
`endif

    // Synchronous SRAM: data appears the cycle after chip select and is held.
    for (genvar g = 0; g < 2; g++) begin : g_sram
        always @(posedge clk) begin
            if (sram_cs[g]) sram_rdata[g] <= mem[sram_addr[g]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int          m_left  [2];  // cycles until the delivery cycle, 0 = no read pending
    bit          m_resp  [2];  // this cycle is a delivery cycle
    bit          m_mis   [2];
    bit          m_disc  [2];
    bit          m_cs    [2];  // SRAM select: the cycle right after acceptance
    logic [AW-1:0] m_addr [2];
    logic [31:0] m_instr [2];

    function automatic int wait_of(int k);
        return (k == 0) ? W0 : W1;
    endfunction

    task automatic model_reset(int k);
        m_left[k] = 0; m_resp[k] = 0; m_mis[k] = 0; m_disc[k] = 0;
        m_cs[k] = 0; m_addr[k] = '0; m_instr[k] = NOP;
    endtask

    task automatic model_step(int k);
        bit was_resp;
        if (rst) begin
            model_reset(k);
            return;
        end
        was_resp  = m_resp[k];
        m_resp[k] = 0;
        m_mis[k]  = 0;
        m_cs[k]   = 0;
        if (m_left[k] > 0) begin
            if (if_flush) m_disc[k] = 1;
            m_left[k]--;
            if (m_left[k] == 0) begin
                if (m_disc[k]) begin
                    m_instr[k] = NOP;
                    m_disc[k]  = 0;
                end else begin
                    m_instr[k] = mem[m_addr[k]];
                    m_resp[k]  = 1;
                end
            end
        end else if (was_resp && if_flush) begin
            m_instr[k] = NOP;
        end else if (if_req && !if_flush) begin
            m_addr[k] = if_addr[AW+1:2];
`ifdef MISALIGN_CHECK_EN
            if (if_addr[1:0] != 2'b00) begin
                m_resp[k]  = 1;
                m_mis[k]   = 1;
                m_instr[k] = NOP;
            end else
`endif
            begin
                m_left[k] = 2 + wait_of(k);
                m_cs[k]   = 1;
            end
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
    end

    // Compare every cycle on the falling edge, then advance the model across
    // the coming rising edge using the inputs that edge will sample.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit busy;
            busy = (m_left[k] > 0);
            check($sformatf("u%0d im_valid", k), 32'(im_valid[k]), 32'(m_resp[k] & ~if_flush));
            check($sformatf("u%0d im_stall", k), 32'(im_stall[k]),
                  32'(!rst && (busy || (!m_resp[k] && if_req && !if_flush))));
            check($sformatf("u%0d im_instr", k), im_instr[k], m_instr[k]);
            check($sformatf("u%0d sram_cs", k), 32'(sram_cs[k]), 32'(m_cs[k]));
            check($sformatf("u%0d sram_oe", k), 32'(sram_oe[k]), 32'(m_cs[k]));
            check($sformatf("u%0d sram_addr", k), 32'(sram_addr[k]), 32'(m_addr[k]));
`ifdef MISALIGN_CHECK_EN
            check($sformatf("u%0d im_misalign", k), 32'(im_mis[k]), 32'(m_mis[k] & ~if_flush));
`endif
            model_step(k);
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle's inputs just after the rising edge; return shortly
    // before the falling edge so directed checks see settled outputs.
    task automatic drive(input logic r, input logic [31:0] a, input logic f, input logic rs);
        @(posedge clk);
        #1;
        if_req = r; if_addr = a; if_flush = f; rst = rs;
        #3;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom | 32'h8000_0000;
        mem[8'h10] = 32'hDEAD_BEEF;

        // Reset, then reset values.
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            check("reset im_instr", im_instr[k], NOP);
            check("reset im_valid", 32'(im_valid[k]), 0);
            check("reset sram_cs", 32'(sram_cs[k]), 0);
            check("reset sram_addr", 32'(sram_addr[k]), 0);
        end
        idle(2);

        // Single fetch of 0x40 on u0 (no wait states).
        drive(1, 32'h40, 0, 0);                       // T0
        check("t1 stall T0", 32'(im_stall[0]), 1);
        drive(0, 0, 0, 0);                            // T1
        check("t1 cs T1", 32'(sram_cs[0]), 1);
        check("t1 addr T1", 32'(sram_addr[0]), 32'h10);
        check("t1 stall T1", 32'(im_stall[0]), 1);
        drive(0, 0, 0, 0);                            // T2
        check("t1 stall T2", 32'(im_stall[0]), 1);
        drive(0, 0, 0, 0);                            // T3
        check("t1 valid T3", 32'(im_valid[0]), 1);
        check("t1 instr T3", im_instr[0], 32'hDEAD_BEEF);
        check("t1 stall T3", 32'(im_stall[0]), 0);
        idle(8);

        // Back-to-back on u1 (three wait states): deliveries at T6, T12, T18.
        for (int t = 0; t <= 18; t++) begin
            drive(t < 18, 32'(4 * (t / 6)), 0, 0);
            if (t == 6 || t == 12 || t == 18) begin
                check("t2 valid", 32'(im_valid[1]), 1);
                check("t2 instr", im_instr[1], mem[(t / 6) - 1]);
            end
            if (t == 7) check("t2 gap valid", 32'(im_valid[1]), 0);
        end
        idle(10);

        // Flush while u0 waits on the SRAM; retry delivers at T7.
        drive(1, 32'h40, 0, 0);                       // T0
        drive(0, 0, 0, 0);                            // T1
        drive(0, 0, 1, 0);                            // T2
        drive(0, 0, 0, 0);                            // T3
        check("t3 valid T3", 32'(im_valid[0]), 0);
        check("t3 instr T3", im_instr[0], NOP);
        check("t3 stall T3", 32'(im_stall[0]), 0);
        drive(1, 32'h44, 0, 0);                       // T4
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);                            // T7
        check("t3 valid T7", 32'(im_valid[0]), 1);
        check("t3 instr T7", im_instr[0], mem[8'h11]);
        idle(10);

        // Flush in the delivery cycle, then flush with request in IDLE.
        drive(1, 32'h48, 0, 0);                       // T0
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 32'h4c, 1, 0);                       // T3 delivery cycle
        check("t4 valid T3", 32'(im_valid[0]), 0);
        check("t4 instr T3", im_instr[0], mem[8'h12]);
        drive(0, 0, 0, 0);                            // T4
        check("t4 instr T4", im_instr[0], NOP);
        check("t4 cs T4", 32'(sram_cs[0]), 0);
        drive(1, 32'h50, 1, 0);                       // T5
        check("t4 idle stall", 32'(im_stall[0]), 0);
        drive(0, 0, 0, 0);                            // T6
        check("t4 idle cs", 32'(sram_cs[0]), 0);
        idle(10);

        // Reset while u1 waits; restart cleanly.
        drive(1, 32'h54, 0, 0);                       // T0
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);                            // T3
        check("t5 stall in rst", 32'(im_stall[1]), 0);
        drive(0, 0, 0, 0);                            // T4
        check("t5 valid", 32'(im_valid[1]), 0);
        check("t5 cs", 32'(sram_cs[1]), 0);
        check("t5 instr", im_instr[1], NOP);
        drive(1, 32'h58, 0, 0);                       // T5
        repeat (5) drive(0, 0, 0, 0);                 // T6..T10
        drive(0, 0, 0, 0);                            // T11
        check("t5 restart valid", 32'(im_valid[1]), 1);
        check("t5 restart instr", im_instr[1], mem[8'h16]);
        idle(10);

`ifdef MISALIGN_CHECK_EN
        drive(1, 32'h42, 0, 0);                       // T0
        drive(0, 0, 0, 0);                            // T1
        check("t6 valid", 32'(im_valid[0]), 1);
        check("t6 misalign", 32'(im_mis[0]), 1);
        check("t6 instr", im_instr[0], NOP);
        check("t6 cs T1", 32'(sram_cs[0]), 0);
        drive(0, 0, 0, 0);                            // T2
        check("t6 cs T2", 32'(sram_cs[0]), 0);
        check("t6 misalign T2", 32'(im_mis[0]), 0);
        idle(4);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            drive($urandom_range(0, 9) < 6, a, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 99) == 0);
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/im_fetch_responder.md
Name: im_fetch_responder

Overview:
Instruction-memory responder for the IF stage. It accepts a fetch address, runs a synchronous single-port SRAM read with a configurable number of wait states, and returns the instruction with a one-cycle valid pulse. While an access is outstanding it asserts a stall so the hazard unit can deassert PC_write. It sits between IF_Stage (o_pc_IM / IM_IF_instr) and the instruction SRAM macro.

Parameters:
ADDR_W, 14, SRAM word-address width (2^ADDR_W 32-bit words).
WAIT_CYCLES, 0, extra cycles inserted after the SRAM read cycle (range 0..15).
RESET_INSTR, 32'h0000_0013, reset/flush value of im_instr (NOP).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request from IF stage
if_addr  in  32  byte fetch address (o_pc_IM)
if_flush  in  1  redirect/flush; cancels delivery of an in-flight fetch
im_instr  out  32  fetched instruction (IM_IF_instr), registered
im_valid  out  1  one-cycle pulse, im_instr valid
im_stall  out  1  hold PC; to hazard unit
sram_cs  out  1  SRAM chip select, registered
sram_oe  out  1  SRAM output enable, registered, equal to sram_cs
sram_addr  out  ADDR_W  SRAM word address = latched if_addr[ADDR_W+1:2]
sram_rdata  in  32  SRAM read data, valid the cycle after sram_cs

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset values: state IDLE, im_instr=RESET_INSTR, im_valid=0, sram_cs=sram_oe=0, sram_addr=0, wait counter=0, discard flag=0. im_stall is forced 0 while rst is high.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: if_req=1 and if_flush=0 → latch address, go to ACCESS. Otherwise stay in IDLE.
- ACCESS (1 cycle): sram_cs=sram_oe=1 and sram_addr is driven. Load counter with WAIT_CYCLES, go to WAIT.
- WAIT: sram_rdata is held stable by the macro. If counter≠0, decrement. If counter=0, capture sram_rdata into im_instr and go to RESP.
- RESP (1 cycle): im_valid=1. If if_req=1 and if_flush=0, accept a new address and go to ACCESS (back-to-back). Otherwise go to IDLE.
- Latency: request accepted in cycle T0 → im_valid in cycle T0+3+WAIT_CYCLES. Back-to-back throughput is one fetch per 3+WAIT_CYCLES cycles.
- im_stall (combinational) = (state==ACCESS) | (state==WAIT) | (state==IDLE & if_req & ~if_flush). It is 0 in RESP, so the PC advances on the delivering edge.
- Flush during ACCESS or WAIT: set the discard flag. The SRAM access still completes, because it cannot be cancelled. At completion, im_instr is loaded with RESET_INSTR, im_valid stays 0, the FSM goes to IDLE, and the discard flag clears. im_stall stays high until that point.
- Flush during RESP: im_valid is forced 0 that cycle, im_instr is loaded with RESET_INSTR on the next edge, and no new request is accepted that cycle.
- Flush in IDLE together with if_req: the request is not accepted and im_stall=0.
- Address handling: only bits [ADDR_W+1:2] are used, so higher bits wrap. The latched address is not affected by if_addr changes after acceptance.
- Reset asserted mid-access: all state returns to reset values on that edge, and the in-flight data is dropped.
- im_instr holds its last value outside RESP.

Optional Feature:
MISALIGN_CHECK_EN
- Defined: accepting if_addr[1:0]≠0 skips ACCESS/WAIT and goes straight to RESP. im_instr=RESET_INSTR and im_valid=1. An extra output im_misalign (1 bit, reset 0) pulses with that im_valid. sram_cs stays 0.
- Undefined: the im_misalign port is absent and if_addr[1:0] is ignored.

Test Plan:
- Preload word 0x10 = 0xDEADBEEF, WAIT_CYCLES=0, if_req=1 with if_addr=0x40 at T0 → sram_cs=1 at T1 with sram_addr=0x10; im_valid=1 and im_instr=0xDEADBEEF at T3; im_stall=1 at T0–T2 and 0 at T3.
- WAIT_CYCLES=3, continuous if_req for addresses 0x0, 0x4, 0x8 → im_valid pulses at T6, T12, T18 with the correct words; no gaps beyond 6 cycles per fetch.
- Request 0x40, then if_flush=1 at T2 (WAIT) → no im_valid; im_instr=0x00000013; FSM in IDLE at T4; a new request at T4 gets its data at T7.
- if_flush=1 in the RESP cycle → im_valid=0 in that cycle and im_instr=0x00000013 on the next cycle; if_flush together with if_req in IDLE → im_stall=0 and sram_cs stays 0.
- rst=1 during WAIT → next cycle: im_valid=0, sram_cs=0, im_instr=0x00000013, state IDLE; the fetch restarts cleanly.
- MISALIGN_CHECK_EN defined, if_addr=0x42 → sram_cs never asserted; im_valid=1 and im_misalign=1 at T1 with im_instr=0x00000013.
